clock_divider: RTL and testbench

CLOCK_DIVIDER -- requirements
Module: clock_divider

---
 rtl/clock_divider_pkg.sv | 22 ++
 rtl/clkdiv_toggle.sv | 34 +++
 rtl/clock_divider.sv | 67 ++++++
 tb/tb_clock_divider.sv | 128 ++++++++++++
 4 files changed

// File: rtl/clock_divider_pkg.sv
// Shared constants and elaboration helpers for the clock divider.
// Build option CLOCK_DIVIDER_CASCADE_EN selects the slow-path derivation.
package clock_divider_pkg;

  localparam int DEF_CLK_FREQ_HZ  = 100_000_000;
  localparam int DEF_FAST_FREQ_HZ = 1000;
  localparam int DEF_SLOW_FREQ_HZ = 1;

  function automatic int half_count(
    input int clk_hz,
    input int out_hz
  );
    return clk_hz / (2 * out_hz);
  endfunction

  function automatic int cnt_width(
    input int half
  );
    return (half > 1) ? $clog2(half) : 1;
  endfunction

endpackage

// File: rtl/clkdiv_toggle.sv
// One divider stage: counts enabled cycles, pulses tick and flips
// toggle_out every HALF_COUNT enables.
module clkdiv_toggle
  import clock_divider_pkg::*;
#(
  parameter int HALF_COUNT = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  output logic tick,
  output logic toggle_out
);

  localparam int W = cnt_width(HALF_COUNT);
  localparam logic [W-1:0] LAST = W'(HALF_COUNT - 1);

  logic [W-1:0] cnt;

  assign tick = enable && (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      toggle_out <= 1'b0;
    end else if (tick) begin
      cnt        <= '0;
      toggle_out <= ~toggle_out;
    end else if (enable) begin
      cnt        <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/clock_divider.sv
// Fast and slow square-wave dividers from one system clock.
// CLOCK_DIVIDER_CASCADE_EN: slow stage counts fast-stage wrap ticks.
module clock_divider
  import clock_divider_pkg::*;
#(
  parameter int CLK_FREQ_HZ  = DEF_CLK_FREQ_HZ,
  parameter int FAST_FREQ_HZ = DEF_FAST_FREQ_HZ,
  parameter int SLOW_FREQ_HZ = DEF_SLOW_FREQ_HZ
) (
  input  logic clk_100MHz,
  input  logic rst_n,
  output logic clk_1kHz,
  output logic clk_1Hz
);

  localparam int FAST_HALF = half_count(CLK_FREQ_HZ, FAST_FREQ_HZ);

  if ((CLK_FREQ_HZ % (2 * FAST_FREQ_HZ)) != 0 ||
      (CLK_FREQ_HZ % (2 * SLOW_FREQ_HZ)) != 0 ||
      (FAST_FREQ_HZ % SLOW_FREQ_HZ) != 0) begin : g_bad_cfg
    $error("clock_divider: frequencies do not divide evenly");
  end

  logic fast_tick;
  logic slow_tick_unused;

  clkdiv_toggle #(
    .HALF_COUNT(FAST_HALF)
  ) u_fast (
    .clk       (clk_100MHz),
    .rst_n     (rst_n),
    .enable    (1'b1),
    .tick      (fast_tick),
    .toggle_out(clk_1kHz)
  );

`ifdef CLOCK_DIVIDER_CASCADE_EN
  // RATIO fast wraps span exactly one slow half period
  localparam int RATIO = FAST_FREQ_HZ / SLOW_FREQ_HZ;

  clkdiv_toggle #(
    .HALF_COUNT(RATIO)
  ) u_slow (
    .clk       (clk_100MHz),
    .rst_n     (rst_n),
    .enable    (fast_tick),
    .tick      (slow_tick_unused),
    .toggle_out(clk_1Hz)
  );
`else
  localparam int SLOW_HALF = half_count(CLK_FREQ_HZ, SLOW_FREQ_HZ);

  logic fast_tick_unused;
  assign fast_tick_unused = fast_tick;

  clkdiv_toggle #(
    .HALF_COUNT(SLOW_HALF)
  ) u_slow (
    .clk       (clk_100MHz),
    .rst_n     (rst_n),
    .enable    (1'b1),
    .tick      (slow_tick_unused),
    .toggle_out(clk_1Hz)
  );
`endif

endmodule

// File: tb/tb_clock_divider.sv
// Randomized reset-interruption bench for clock_divider against
// an edge-count arithmetic reference model.
module tb_clock_divider;

  localparam int CLK  = 1000;
  localparam int FAST = 100;
  localparam int SLOW = 10;
  localparam int FH   = CLK / (2 * FAST);
  localparam int SH   = CLK / (2 * SLOW);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic f;
  logic s;

  int tests = 0;
  int fails = 0;
  int n = 0;
  int last_f = 0;
  int last_s = 0;
  logic prev_f = 1'b0;
  logic prev_s = 1'b0;

  always #5 clk = ~clk;

  clock_divider #(
    .CLK_FREQ_HZ (CLK),
    .FAST_FREQ_HZ(FAST),
    .SLOW_FREQ_HZ(SLOW)
  ) dut (
    .clk_100MHz(clk),
    .rst_n     (rst_n),
    .clk_1kHz  (f),
    .clk_1Hz   (s)
  );

  task automatic chk(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic restart();
    n = 0;
    last_f = 0;
    last_s = 0;
    prev_f = 1'b0;
    prev_s = 1'b0;
  endtask

  // n = rising edges since release; each output is a square wave of it
  task automatic run(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      n++;
      chk("fast_level", f, logic'((n / FH) % 2));
      chk("slow_level", s, logic'((n / SH) % 2));
      if (f !== prev_f) begin
        chk_int("fast_interval", n - last_f, FH);
        last_f = n;
      end
      if (s !== prev_s) begin
        chk_int("slow_interval", n - last_s, SH);
        chk("slow_on_fast_edge", f !== prev_f, 1'b1);
        last_s = n;
      end
      prev_f = f;
      prev_s = s;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    #1;
    chk("reset_fast_t1", f, 1'b0);
    chk("reset_slow_t1", s, 1'b0);
    #30;
    chk("reset_fast_t31", f, 1'b0);
    chk("reset_slow_t31", s, 1'b0);
    #21;
    rst_n = 1'b1;
    restart();
    #1;
    chk("release_fast", f, 1'b0);
    chk("release_slow", s, 1'b0);

    run(FH - 1);
    chk("pre_first_rise", f, 1'b0);
    run(1);
    chk_int("first_rise_ns", int'($time) - 1, FH * 10 - 5 + 50);
    run(2 * SH + 7);

    for (int k = 0; k < 6; k++) begin
      run($urandom_range(1, 3 * SH));
      #($urandom_range(1, 3));
      rst_n = 1'b0;
      #1;
      chk("async_fast_zero", f, 1'b0);
      chk("async_slow_zero", s, 1'b0);
      repeat ($urandom_range(1, 3)) begin
        @(posedge clk);
        #1;
        chk("hold_fast_zero", f, 1'b0);
        chk("hold_slow_zero", s, 1'b0);
      end
      @(negedge clk);
      #($urandom_range(0, 3));
      rst_n = 1'b1;
      restart();
    end
    run(2 * SH + 3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
